// File: rtl/axi_rd_reg_slice_pkg.sv
// Shared AXI read-path widths, payload structs and skid buffer state type.
`ifndef AXI_DEFINES_SVH
`define AXI_DEFINES_SVH
`define AXI_ID_WIDTH     4
`define AXI_ADDR_WIDTH   32
`define AXI_LEN_WIDTH    8
`define AXI_SIZE_WIDTH   3
`define AXI_BURST_WIDTH  2
`define AXI_DATA_WIDTH   32
`define AXI_RESP_WIDTH   2
`define AXI_AR_PLD_WIDTH (`AXI_ID_WIDTH + `AXI_ADDR_WIDTH + `AXI_LEN_WIDTH + `AXI_SIZE_WIDTH + `AXI_BURST_WIDTH)
`define AXI_R_PLD_WIDTH  (`AXI_ID_WIDTH + `AXI_DATA_WIDTH + `AXI_RESP_WIDTH + 1)
`endif

package axi_rd_reg_slice_pkg;

  localparam int unsigned ID_W     = `AXI_ID_WIDTH;
  localparam int unsigned ADDR_W   = `AXI_ADDR_WIDTH;
  localparam int unsigned LEN_W    = `AXI_LEN_WIDTH;
  localparam int unsigned SIZE_W   = `AXI_SIZE_WIDTH;
  localparam int unsigned BURST_W  = `AXI_BURST_WIDTH;
  localparam int unsigned DATA_W   = `AXI_DATA_WIDTH;
  localparam int unsigned RESP_W   = `AXI_RESP_WIDTH;
  localparam int unsigned AR_PLD_W = `AXI_AR_PLD_WIDTH;
  localparam int unsigned R_PLD_W  = `AXI_R_PLD_WIDTH;

  // AR payload, field order fixed as {id, addr, len, size, burst}
  typedef struct packed {
    logic [ID_W-1:0]    id;
    logic [ADDR_W-1:0]  addr;
    logic [LEN_W-1:0]   len;
    logic [SIZE_W-1:0]  size;
    logic [BURST_W-1:0] burst;
  } ar_pld_t;

  // R payload, field order fixed as {id, data, resp, last}
  typedef struct packed {
    logic [ID_W-1:0]   id;
    logic [DATA_W-1:0] data;
    logic [RESP_W-1:0] resp;
    logic              last;
  } r_pld_t;

  typedef enum logic [1:0] {
    SKID_EMPTY = 2'd0,
    SKID_BUSY  = 2'd1,
    SKID_FULL  = 2'd2
  } skid_state_e;

endpackage

// File: rtl/skid_slice.sv
// Two-entry skid buffer: one output register plus one skid register,
// with registered valid and ready so no input reaches an output combinationally.
module skid_slice
  import axi_rd_reg_slice_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  skid_state_e      state_q, state_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [WIDTH-1:0] skid_data_q, skid_data_d;
  logic             out_valid_q, out_valid_d;
  logic             in_ready_q, in_ready_d;
  logic             push, pop;

  assign push = in_valid && in_ready_q;
  assign pop  = out_valid_q && out_ready;

  // Next state and data movement; the skid register only fills while the output is stalled
  always_comb begin
    state_d     = state_q;
    out_data_d  = out_data_q;
    skid_data_d = skid_data_q;
    unique case (state_q)
      SKID_EMPTY: begin
        if (push) begin
          state_d    = SKID_BUSY;
          out_data_d = in_data;
        end
      end
      SKID_BUSY: begin
        if (push && pop) begin
          out_data_d = in_data;
        end else if (push) begin
          state_d     = SKID_FULL;
          skid_data_d = in_data;
        end else if (pop) begin
          state_d = SKID_EMPTY;
        end
      end
      SKID_FULL: begin
        if (pop) begin
          state_d    = SKID_BUSY;
          out_data_d = skid_data_q;
        end
      end
      default: begin
        state_d = SKID_EMPTY;
      end
    endcase
    out_valid_d = (state_d != SKID_EMPTY);
    in_ready_d  = (state_d != SKID_FULL);
  end

  // State and payload registers; reset drops valid and ready immediately
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= SKID_EMPTY;
      out_data_q  <= '0;
      skid_data_q <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      out_data_q  <= out_data_d;
      skid_data_q <= skid_data_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

endmodule

// File: rtl/axi_rd_reg_slice.sv
// AXI read-path register slice: optional skid stage on AR (master->slave)
// and on R (slave->master). Payload is carried opaquely.
module axi_rd_reg_slice
  import axi_rd_reg_slice_pkg::*;
#(
  parameter bit AR_PIPE = 1'b1,
  parameter bit R_PIPE  = 1'b1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  // AR from master
  input  logic [`AXI_ID_WIDTH-1:0]     axi_slv_arid,
  input  logic [`AXI_ADDR_WIDTH-1:0]   axi_slv_araddr,
  input  logic [`AXI_LEN_WIDTH-1:0]    axi_slv_arlen,
  input  logic [`AXI_SIZE_WIDTH-1:0]   axi_slv_arsize,
  input  logic [`AXI_BURST_WIDTH-1:0]  axi_slv_arburst,
  input  logic                         axi_slv_arvalid,
  output logic                         axi_slv_arready,
  // AR to slave
  output logic [`AXI_ID_WIDTH-1:0]     axi_mst_arid,
  output logic [`AXI_ADDR_WIDTH-1:0]   axi_mst_araddr,
  output logic [`AXI_LEN_WIDTH-1:0]    axi_mst_arlen,
  output logic [`AXI_SIZE_WIDTH-1:0]   axi_mst_arsize,
  output logic [`AXI_BURST_WIDTH-1:0]  axi_mst_arburst,
  output logic                         axi_mst_arvalid,
  input  logic                         axi_mst_arready,
  // R from slave
  input  logic [`AXI_ID_WIDTH-1:0]     axi_mst_rid,
  input  logic [`AXI_DATA_WIDTH-1:0]   axi_mst_rdata,
  input  logic [`AXI_RESP_WIDTH-1:0]   axi_mst_rresp,
  input  logic                         axi_mst_rlast,
  input  logic                         axi_mst_rvalid,
  output logic                         axi_mst_rready,
  // R to master
  output logic [`AXI_ID_WIDTH-1:0]     axi_slv_rid,
  output logic [`AXI_DATA_WIDTH-1:0]   axi_slv_rdata,
  output logic [`AXI_RESP_WIDTH-1:0]   axi_slv_rresp,
  output logic                         axi_slv_rlast,
  output logic                         axi_slv_rvalid,
  input  logic                         axi_slv_rready
);

  // AR channel: skid stage or straight wires
  if (AR_PIPE) begin : g_ar_pipe
    ar_pld_t ar_in_pld;
    ar_pld_t ar_out_pld;

    assign ar_in_pld = '{id:    axi_slv_arid,
                         addr:  axi_slv_araddr,
                         len:   axi_slv_arlen,
                         size:  axi_slv_arsize,
                         burst: axi_slv_arburst};

    skid_slice #(
      .WIDTH (AR_PLD_W)
    ) u_ar_skid (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (axi_slv_arvalid),
      .in_ready  (axi_slv_arready),
      .in_data   (ar_in_pld),
      .out_valid (axi_mst_arvalid),
      .out_ready (axi_mst_arready),
      .out_data  (ar_out_pld)
    );

    assign axi_mst_arid    = ar_out_pld.id;
    assign axi_mst_araddr  = ar_out_pld.addr;
    assign axi_mst_arlen   = ar_out_pld.len;
    assign axi_mst_arsize  = ar_out_pld.size;
    assign axi_mst_arburst = ar_out_pld.burst;
  end else begin : g_ar_wire
    assign axi_mst_arid    = axi_slv_arid;
    assign axi_mst_araddr  = axi_slv_araddr;
    assign axi_mst_arlen   = axi_slv_arlen;
    assign axi_mst_arsize  = axi_slv_arsize;
    assign axi_mst_arburst = axi_slv_arburst;
    assign axi_mst_arvalid = axi_slv_arvalid;
    assign axi_slv_arready = axi_mst_arready;
  end

  // R channel: skid stage or straight wires; rlast rides inside the payload
  if (R_PIPE) begin : g_r_pipe
    r_pld_t r_in_pld;
    r_pld_t r_out_pld;

    assign r_in_pld = '{id:   axi_mst_rid,
                        data: axi_mst_rdata,
                        resp: axi_mst_rresp,
                        last: axi_mst_rlast};

    skid_slice #(
      .WIDTH (R_PLD_W)
    ) u_r_skid (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (axi_mst_rvalid),
      .in_ready  (axi_mst_rready),
      .in_data   (r_in_pld),
      .out_valid (axi_slv_rvalid),
      .out_ready (axi_slv_rready),
      .out_data  (r_out_pld)
    );

    assign axi_slv_rid   = r_out_pld.id;
    assign axi_slv_rdata = r_out_pld.data;
    assign axi_slv_rresp = r_out_pld.resp;
    assign axi_slv_rlast = r_out_pld.last;
  end else begin : g_r_wire
    assign axi_slv_rid    = axi_mst_rid;
    assign axi_slv_rdata  = axi_mst_rdata;
    assign axi_slv_rresp  = axi_mst_rresp;
    assign axi_slv_rlast  = axi_mst_rlast;
    assign axi_slv_rvalid = axi_mst_rvalid;
    assign axi_mst_rready = axi_slv_rready;
  end

endmodule

// File: tb/tb_axi_rd_reg_slice.sv
// Bench for axi_rd_reg_slice: directed latency/backpressure/reset cases plus
// randomized traffic, with a FIFO scoreboard per channel.
module tb_axi_rd_reg_slice;
  import axi_rd_reg_slice_pkg::*;

  localparam int RAND_BEATS = 500;
  localparam int MAX_CYC    = 20000;

  logic               clk;
  logic               rst_n;
  logic [ID_W-1:0]    axi_slv_arid;
  logic [ADDR_W-1:0]  axi_slv_araddr;
  logic [LEN_W-1:0]   axi_slv_arlen;
  logic [SIZE_W-1:0]  axi_slv_arsize;
  logic [BURST_W-1:0] axi_slv_arburst;
  logic               axi_slv_arvalid;
  logic               axi_slv_arready;
  logic [ID_W-1:0]    axi_mst_arid;
  logic [ADDR_W-1:0]  axi_mst_araddr;
  logic [LEN_W-1:0]   axi_mst_arlen;
  logic [SIZE_W-1:0]  axi_mst_arsize;
  logic [BURST_W-1:0] axi_mst_arburst;
  logic               axi_mst_arvalid;
  logic               axi_mst_arready;
  logic [ID_W-1:0]    axi_mst_rid;
  logic [DATA_W-1:0]  axi_mst_rdata;
  logic [RESP_W-1:0]  axi_mst_rresp;
  logic               axi_mst_rlast;
  logic               axi_mst_rvalid;
  logic               axi_mst_rready;
  logic [ID_W-1:0]    axi_slv_rid;
  logic [DATA_W-1:0]  axi_slv_rdata;
  logic [RESP_W-1:0]  axi_slv_rresp;
  logic               axi_slv_rlast;
  logic               axi_slv_rvalid;
  logic               axi_slv_rready;

  axi_rd_reg_slice dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .axi_slv_arid    (axi_slv_arid),
    .axi_slv_araddr  (axi_slv_araddr),
    .axi_slv_arlen   (axi_slv_arlen),
    .axi_slv_arsize  (axi_slv_arsize),
    .axi_slv_arburst (axi_slv_arburst),
    .axi_slv_arvalid (axi_slv_arvalid),
    .axi_slv_arready (axi_slv_arready),
    .axi_mst_arid    (axi_mst_arid),
    .axi_mst_araddr  (axi_mst_araddr),
    .axi_mst_arlen   (axi_mst_arlen),
    .axi_mst_arsize  (axi_mst_arsize),
    .axi_mst_arburst (axi_mst_arburst),
    .axi_mst_arvalid (axi_mst_arvalid),
    .axi_mst_arready (axi_mst_arready),
    .axi_mst_rid     (axi_mst_rid),
    .axi_mst_rdata   (axi_mst_rdata),
    .axi_mst_rresp   (axi_mst_rresp),
    .axi_mst_rlast   (axi_mst_rlast),
    .axi_mst_rvalid  (axi_mst_rvalid),
    .axi_mst_rready  (axi_mst_rready),
    .axi_slv_rid     (axi_slv_rid),
    .axi_slv_rdata   (axi_slv_rdata),
    .axi_slv_rresp   (axi_slv_rresp),
    .axi_slv_rlast   (axi_slv_rlast),
    .axi_slv_rvalid  (axi_slv_rvalid),
    .axi_slv_rready  (axi_slv_rready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Payload views of both sides of each channel
  ar_pld_t ar_in_pld, ar_out_pld;
  r_pld_t  r_in_pld, r_out_pld;
  assign ar_in_pld  = {axi_slv_arid, axi_slv_araddr, axi_slv_arlen, axi_slv_arsize, axi_slv_arburst};
  assign ar_out_pld = {axi_mst_arid, axi_mst_araddr, axi_mst_arlen, axi_mst_arsize, axi_mst_arburst};
  assign r_in_pld   = {axi_mst_rid, axi_mst_rdata, axi_mst_rresp, axi_mst_rlast};
  assign r_out_pld  = {axi_slv_rid, axi_slv_rdata, axi_slv_rresp, axi_slv_rlast};

  int checks   = 0;
  int failures = 0;

  // Reference model: each channel is an in-order FIFO of accepted beats
  ar_pld_t ar_q[$];
  r_pld_t  r_q[$];
  int      ar_rcvd = 0;
  int      r_rcvd  = 0;
  bit      ar_hold_v = 1'b0;
  bit      r_hold_v  = 1'b0;
  ar_pld_t ar_hold_pld;
  r_pld_t  r_hold_pld;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic empty_pop(input string name);
    checks++;
    failures++;
    $display("FAIL %s: output beat with no expected beat queued at %0t", name, $time);
  endtask

  // Monitor: checks stalled outputs hold, pops on downstream handshake, pushes on upstream handshake
  always @(negedge clk) begin
    if (!rst_n) begin
      ar_q.delete();
      r_q.delete();
      ar_hold_v = 1'b0;
      r_hold_v  = 1'b0;
    end else begin
      if (ar_hold_v) begin
        check("ar_hold_valid", 64'(axi_mst_arvalid), 64'(1));
        check("ar_hold_payload", 64'(ar_out_pld), 64'(ar_hold_pld));
      end
      if (r_hold_v) begin
        check("r_hold_valid", 64'(axi_slv_rvalid), 64'(1));
        check("r_hold_payload", 64'(r_out_pld), 64'(r_hold_pld));
      end
      if (axi_mst_arvalid && axi_mst_arready) begin
        if (ar_q.size() == 0) empty_pop("ar_scoreboard");
        else check("ar_scoreboard", 64'(ar_out_pld), 64'(ar_q.pop_front()));
        ar_rcvd++;
      end
      if (axi_slv_rvalid && axi_slv_rready) begin
        if (r_q.size() == 0) empty_pop("r_scoreboard");
        else check("r_scoreboard", 64'(r_out_pld), 64'(r_q.pop_front()));
        r_rcvd++;
      end
      if (axi_slv_arvalid && axi_slv_arready) ar_q.push_back(ar_in_pld);
      if (axi_mst_rvalid && axi_mst_rready) r_q.push_back(r_in_pld);
      ar_hold_v   = axi_mst_arvalid && !axi_mst_arready;
      ar_hold_pld = ar_out_pld;
      r_hold_v    = axi_slv_rvalid && !axi_slv_rready;
      r_hold_pld  = r_out_pld;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One clock: report which upstream handshakes happen at the coming edge
  task automatic cycle(output bit acc_ar, output bit acc_r);
    @(negedge clk);
    acc_ar = axi_slv_arvalid && axi_slv_arready;
    acc_r  = axi_mst_rvalid && axi_mst_rready;
    @(posedge clk);
    #1;
  endtask

  task automatic drive_r(input logic [DATA_W-1:0] data, input logic last);
    axi_mst_rvalid = 1'b1;
    axi_mst_rid    = ID_W'(1);
    axi_mst_rdata  = data;
    axi_mst_rresp  = '0;
    axi_mst_rlast  = last;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    bit acc_ar, acc_r;
    int idx, n, ar_issued, r_issued, ar_base, r_base;

    rst_n           = 1'b0;
    axi_slv_arid    = '0;
    axi_slv_araddr  = '0;
    axi_slv_arlen   = '0;
    axi_slv_arsize  = '0;
    axi_slv_arburst = '0;
    axi_slv_arvalid = 1'b0;
    axi_mst_arready = 1'b0;
    axi_mst_rid     = '0;
    axi_mst_rdata   = '0;
    axi_mst_rresp   = '0;
    axi_mst_rlast   = 1'b0;
    axi_mst_rvalid  = 1'b0;
    axi_slv_rready  = 1'b0;

    // Reset held for 3 cycles
    repeat (3) tick();
    check("rst_arready", 64'(axi_slv_arready), 64'(0));
    check("rst_rready", 64'(axi_mst_rready), 64'(0));
    check("rst_arvalid", 64'(axi_mst_arvalid), 64'(0));
    check("rst_rvalid", 64'(axi_slv_rvalid), 64'(0));
    rst_n = 1'b1;
    check("rel_arready_pre_edge", 64'(axi_slv_arready), 64'(0));
    tick();
    check("rel_arready", 64'(axi_slv_arready), 64'(1));
    check("rel_rready", 64'(axi_mst_rready), 64'(1));

    // AR single beat, 1-cycle forward latency
    axi_mst_arready = 1'b1;
    axi_slv_arvalid = 1'b1;
    axi_slv_arid    = ID_W'(2);
    axi_slv_araddr  = ADDR_W'(32'h0000_1000);
    axi_slv_arlen   = LEN_W'(3);
    axi_slv_arsize  = SIZE_W'(2);
    axi_slv_arburst = BURST_W'(1);
    check("ar_single_pre", 64'(axi_mst_arvalid), 64'(0));
    cycle(acc_ar, acc_r);
    check("ar_single_accept", 64'(acc_ar), 64'(1));
    axi_slv_arvalid = 1'b0;
    check("ar_single_valid", 64'(axi_mst_arvalid), 64'(1));
    check("ar_single_addr", 64'(axi_mst_araddr), 64'(32'h0000_1000));
    check("ar_single_len", 64'(axi_mst_arlen), 64'(3));
    check("ar_single_id", 64'(axi_mst_arid), 64'(2));
    cycle(acc_ar, acc_r);
    check("ar_single_done", 64'(axi_mst_arvalid), 64'(0));
    check("ar_single_q", 64'(ar_q.size()), 64'(0));

    // R streaming, both sides always ready
    axi_slv_rready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive_r(DATA_W'(32'hA0 + i), i == 3);
      cycle(acc_ar, acc_r);
      check("r_stream_valid", 64'(axi_slv_rvalid), 64'(1));
      check("r_stream_data", 64'(axi_slv_rdata), 64'(32'hA0 + i));
      check("r_stream_last", 64'(axi_slv_rlast), 64'(i == 3));
    end
    axi_mst_rvalid = 1'b0;
    axi_mst_rlast  = 1'b0;
    cycle(acc_ar, acc_r);
    check("r_stream_idle", 64'(axi_slv_rvalid), 64'(0));
    check("r_stream_q", 64'(r_q.size()), 64'(0));

    // Backpressure: master stalls 5 cycles mid-burst
    r_base = r_rcvd;
    idx = 0;
    for (int c = 0; c < 16; c++) begin
      axi_slv_rready = !(c >= 1 && c <= 5);
      if (idx < 4) drive_r(DATA_W'(32'hB0 + idx), idx == 3);
      else axi_mst_rvalid = 1'b0;
      if (c == 1) check("bp_ready_one_late", 64'(axi_mst_rready), 64'(1));
      if (c == 2 || c == 5) begin
        check("bp_full_ready", 64'(axi_mst_rready), 64'(0));
        check("bp_full_data", 64'(axi_slv_rdata), 64'(32'hB0));
      end
      cycle(acc_ar, acc_r);
      if (acc_r) idx++;
    end
    axi_mst_rlast = 1'b0;
    check("bp_beats", 64'(r_rcvd - r_base), 64'(4));
    check("bp_q", 64'(r_q.size()), 64'(0));

    // Random valid/ready toggling on both channels
    ar_base = ar_rcvd;
    r_base  = r_rcvd;
    ar_issued = 0;
    r_issued  = 0;
    n = 0;
    acc_ar = 1'b1;
    acc_r  = 1'b1;
    while ((ar_issued < RAND_BEATS || r_issued < RAND_BEATS || axi_slv_arvalid || axi_mst_rvalid) && n < MAX_CYC) begin
      if (!axi_slv_arvalid || acc_ar) begin
        if (ar_issued < RAND_BEATS && $urandom_range(0, 3) != 0) begin
          axi_slv_arvalid = 1'b1;
          axi_slv_arid    = ID_W'($urandom());
          axi_slv_araddr  = ADDR_W'($urandom());
          axi_slv_arlen   = LEN_W'($urandom());
          axi_slv_arsize  = SIZE_W'($urandom());
          axi_slv_arburst = BURST_W'($urandom());
          ar_issued++;
        end else begin
          axi_slv_arvalid = 1'b0;
        end
      end
      if (!axi_mst_rvalid || acc_r) begin
        if (r_issued < RAND_BEATS && $urandom_range(0, 3) != 0) begin
          axi_mst_rvalid = 1'b1;
          axi_mst_rid    = ID_W'($urandom());
          axi_mst_rdata  = DATA_W'($urandom());
          axi_mst_rresp  = RESP_W'($urandom());
          axi_mst_rlast  = 1'($urandom_range(0, 1));
          r_issued++;
        end else begin
          axi_mst_rvalid = 1'b0;
        end
      end
      axi_mst_arready = 1'($urandom_range(0, 1));
      axi_slv_rready  = ($urandom_range(0, 3) != 0);
      cycle(acc_ar, acc_r);
      n++;
    end
    check("rand_bounded", 64'(n < MAX_CYC), 64'(1));
    axi_mst_arready = 1'b1;
    axi_slv_rready  = 1'b1;
    repeat (4) tick();
    check("rand_ar_beats", 64'(ar_rcvd - ar_base), 64'(RAND_BEATS));
    check("rand_r_beats", 64'(r_rcvd - r_base), 64'(RAND_BEATS));
    check("rand_ar_q", 64'(ar_q.size()), 64'(0));
    check("rand_r_q", 64'(r_q.size()), 64'(0));

    // Reset mid-burst with the R slice full (2 beats) and one AR beat held
    axi_slv_rready  = 1'b0;
    axi_mst_arready = 1'b0;
    drive_r(DATA_W'(32'hC0), 1'b0);
    axi_slv_arvalid = 1'b1;
    axi_slv_araddr  = ADDR_W'(32'h0000_2000);
    cycle(acc_ar, acc_r);
    axi_slv_arvalid = 1'b0;
    drive_r(DATA_W'(32'hC1), 1'b1);
    cycle(acc_ar, acc_r);
    axi_mst_rvalid = 1'b0;
    axi_mst_rlast  = 1'b0;
    check("mid_full_ready", 64'(axi_mst_rready), 64'(0));
    check("mid_full_rvalid", 64'(axi_slv_rvalid), 64'(1));
    check("mid_arvalid", 64'(axi_mst_arvalid), 64'(1));
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_rvalid", 64'(axi_slv_rvalid), 64'(0));
    check("mid_rst_arvalid", 64'(axi_mst_arvalid), 64'(0));
    check("mid_rst_rready", 64'(axi_mst_rready), 64'(0));
    tick();
    rst_n = 1'b1;
    tick();
    check("post_rst_rready", 64'(axi_mst_rready), 64'(1));
    check("post_rst_arready", 64'(axi_slv_arready), 64'(1));
    check("post_rst_rvalid", 64'(axi_slv_rvalid), 64'(0));

    // Clean transaction after recovery
    ar_base = ar_rcvd;
    r_base  = r_rcvd;
    axi_slv_rready  = 1'b1;
    axi_mst_arready = 1'b1;
    drive_r(DATA_W'(32'hD0), 1'b1);
    axi_slv_arvalid = 1'b1;
    axi_slv_araddr  = ADDR_W'(32'h0000_3000);
    cycle(acc_ar, acc_r);
    axi_mst_rvalid  = 1'b0;
    axi_mst_rlast   = 1'b0;
    axi_slv_arvalid = 1'b0;
    check("post_rst_rdata", 64'(axi_slv_rdata), 64'(32'hD0));
    check("post_rst_araddr", 64'(axi_mst_araddr), 64'(32'h0000_3000));
    tick();
    tick();
    check("post_rst_ar_beats", 64'(ar_rcvd - ar_base), 64'(1));
    check("post_rst_r_beats", 64'(r_rcvd - r_base), 64'(1));
    check("post_rst_q", 64'(ar_q.size() + r_q.size()), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
